// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbWait,
    ArbAck
  } arb_state_t;

  // Wide enough for the largest legal starvation limit (255).
  localparam int unsigned WaitCntW = 8;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Loader/debug port handshake: request with a stable command, one-cycle ack with read data.
interface data_memory_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  l_req;
  logic                  l_wr_en;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wr_data;
  logic                  l_ack;
  logic [DATA_WIDTH-1:0] l_rd_data;

  // Loader side.
  modport master (
    output l_req,
    output l_wr_en,
    output l_addr,
    output l_wr_data,
    input  l_ack,
    input  l_rd_data
  );

  // Arbiter side.
  modport slave (
    input  l_req,
    input  l_wr_en,
    input  l_addr,
    input  l_wr_data,
    output l_ack,
    output l_rd_data
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the pipeline M stage and a loader port.
// The pipeline wins by default; a loader that waits STARVE_LIMIT cycles is forced
// through and stalls M for exactly one cycle.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // Pipeline memory stage
  input  logic                   i_access_M,
  input  logic                   i_wr_en_M,
  input  logic [ADDR_WIDTH-1:0]  i_addr_M,
  input  logic [DATA_WIDTH-1:0]  i_wr_data_M,
  output logic [DATA_WIDTH-1:0]  o_rd_data_M,
  output logic                   o_stall_M,
  // Loader port
  data_memory_arbiter_if.slave   l_if,
  // Data memory
  output logic                   o_mem_we,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  output logic [DATA_WIDTH-1:0]  o_mem_wd,
  input  logic [DATA_WIDTH-1:0]  i_mem_rd,
  // Status
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  arb_state_t             state_q, state_d;
  logic [WaitCntW-1:0]    cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   grant_l;
  logic                   stall_m;

  // Next-state logic: FSM, wait counter and forced-stall counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    grant_l     = 1'b0;
    stall_m     = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        if (l_if.l_req && !i_access_M) begin
          grant_l = 1'b1;
          state_d = ArbAck;
        end else if (l_if.l_req) begin
          state_d = ArbWait;
          cnt_d   = WaitCntW'(1);
        end
      end
      ArbWait: begin
        if (!l_if.l_req) begin
          // Request withdrawn: abandon without touching memory.
          state_d = ArbIdle;
          cnt_d   = '0;
        end else if (!i_access_M) begin
          grant_l = 1'b1;
          state_d = ArbAck;
          cnt_d   = '0;
        end else if (cnt_q == WaitCntW'(STARVE_LIMIT)) begin
          grant_l = 1'b1;
          stall_m = 1'b1;
          state_d = ArbAck;
          cnt_d   = '0;
          if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + WaitCntW'(1);
        end
      end
      ArbAck: begin
        // Request is ignored here so a held req cannot be served twice per ack.
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Ack pulse and loader read-data capture on the grant cycle.
  always_comb begin
    ack_d     = grant_l;
    rd_data_d = rd_data_q;
    if (grant_l && !l_if.l_wr_en) begin
      rd_data_d = i_mem_rd;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      rd_data_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rd_data_q   <= rd_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory port mux; a stalled M op never writes because the loader owns the port then.
  always_comb begin
    if (grant_l) begin
      o_mem_we   = l_if.l_wr_en;
      o_mem_addr = l_if.l_addr;
      o_mem_wd   = l_if.l_wr_data;
    end else begin
      o_mem_we   = i_access_M & i_wr_en_M;
      o_mem_addr = i_addr_M;
      o_mem_wd   = i_wr_data_M;
    end
  end

  assign o_rd_data_M    = i_mem_rd;
  assign o_stall_M      = stall_m;
  assign l_if.l_ack     = ack_q;
  assign l_if.l_rd_data = rd_data_q;
  assign o_stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: models the data memory, drives both ports and
// checks loader acks against a scoreboard of expected results.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_access_M, i_wr_en_M;
  logic [31:0] i_addr_M, i_wr_data_M, o_rd_data_M;
  logic        o_stall_M;
  logic        o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wd, i_mem_rd;
  logic [15:0] o_stall_count;

  data_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) l_if ();

  data_memory_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(8), .STALL_CNT_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_access_M   (i_access_M),
    .i_wr_en_M    (i_wr_en_M),
    .i_addr_M     (i_addr_M),
    .i_wr_data_M  (i_wr_data_M),
    .o_rd_data_M  (o_rd_data_M),
    .o_stall_M    (o_stall_M),
    .l_if         (l_if),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wd     (o_mem_wd),
    .i_mem_rd     (i_mem_rd),
    .o_stall_count(o_stall_count)
  );

  always #5 clk = ~clk;

  // Word-addressed data memory model with combinational read.
  logic [31:0] mem [0:255];
  logic        mem_clear;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (o_mem_we) begin
      mem[o_mem_addr[9:2]] <= o_mem_wd;
      wr_count <= wr_count + 1;
    end
  end

  assign i_mem_rd = mem[o_mem_addr[9:2]];

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input bit is_read, input logic [31:0] data);
    sb_t e;
    e.is_read = is_read;
    e.data    = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(output sb_t e, output bit ok);
    ok = (sb_q.size() != 0);
    if (ok) e = sb_q.pop_front();
  endtask

  task automatic idle_inputs();
    i_access_M     = 1'b0;
    i_wr_en_M      = 1'b0;
    i_addr_M       = '0;
    i_wr_data_M    = '0;
    l_if.l_req     = 1'b0;
    l_if.l_wr_en   = 1'b0;
    l_if.l_addr    = '0;
    l_if.l_wr_data = '0;
  endtask

  // Holds a loader request until ack or budget expiry; lat = -1 on timeout.
  task automatic loader_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input int max_cycles, output int lat, output int stalls);
    lat = -1;
    stalls = 0;
    l_if.l_req     = 1'b1;
    l_if.l_wr_en   = wr;
    l_if.l_addr    = addr;
    l_if.l_wr_data = data;
    for (int i = 0; i <= max_cycles; i++) begin
      #1;
      if (l_if.l_ack) begin
        lat = i;
        break;
      end
      if (o_stall_M) stalls++;
      step();
    end
    l_if.l_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    mem_clear = 1'b1;
    step();
    step();
    rst = 1'b0;
    mem_clear = 1'b0;
    #1;
    checks++; if (l_if.l_ack !== 1'b0) begin errors++;
      $display("FAIL reset_ack: got %b expected 0", l_if.l_ack); end
    checks++; if (l_if.l_rd_data !== 32'h0) begin errors++;
      $display("FAIL reset_rd_data: got %h expected 0", l_if.l_rd_data); end
    checks++; if (o_stall_count !== 16'h0) begin errors++;
      $display("FAIL reset_stall_count: got %0d expected 0", o_stall_count); end
    checks++; if (o_stall_M !== 1'b0 || o_mem_we !== 1'b0) begin errors++;
      $display("FAIL reset_outputs: stall %b we %b expected 0 0", o_stall_M, o_mem_we); end
  endtask

  task automatic test_idle_share();
    sb_t e; bit ok;
    step();
    l_if.l_req = 1'b1; l_if.l_wr_en = 1'b1;
    l_if.l_addr = 32'h40; l_if.l_wr_data = 32'hDEADBEEF;
    sb_push(1'b0, 32'hDEADBEEF);
    #1;
    checks++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h40 || o_mem_wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t1_grant: we %b addr %h wd %h expected 1 40 deadbeef",
               o_mem_we, o_mem_addr, o_mem_wd);
    end
    checks++; if (o_stall_M !== 1'b0 || l_if.l_ack !== 1'b0) begin errors++;
      $display("FAIL t1_grant_flags: stall %b ack %b expected 0 0", o_stall_M, l_if.l_ack); end
    step();
    #1;
    checks++; if (l_if.l_ack !== 1'b1 || o_stall_M !== 1'b0) begin errors++;
      $display("FAIL t1_ack: ack %b stall %b expected 1 0", l_if.l_ack, o_stall_M); end
    l_if.l_req = 1'b0;
    sb_pop(e, ok);
    checks++; if (!ok || e.is_read) begin errors++;
      $display("FAIL t1_scoreboard: got entry %b expected a write entry", ok); end
    step();
    checks++; if (mem[8'h10] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL t1_mem: got %h expected deadbeef", mem[8'h10]); end
  endtask

  task automatic test_read_back();
    sb_t e; bit ok; int lat, stalls;
    step();
    sb_push(1'b1, 32'hDEADBEEF);
    loader_xfer(1'b0, 32'h40, 32'h0, 20, lat, stalls);
    checks++; if (lat != 1 || stalls != 0) begin errors++;
      $display("FAIL t2_latency: got lat %0d stalls %0d expected 1 0", lat, stalls); end
    sb_pop(e, ok);
    checks++; if (!ok || l_if.l_rd_data !== e.data) begin errors++;
      $display("FAIL t2_rd_data: got %h expected %h", l_if.l_rd_data, e.data); end
    step();
    #1;
    checks++; if (l_if.l_ack !== 1'b0 || l_if.l_rd_data !== 32'hDEADBEEF) begin errors++;
      $display("FAIL t2_hold: ack %b data %h expected 0 deadbeef", l_if.l_ack, l_if.l_rd_data);
    end
  endtask

  task automatic test_starvation();
    sb_t e; bit ok; int lat, stalls;
    step();
    i_access_M = 1'b1; i_wr_en_M = 1'b0; i_addr_M = 32'h100;
    sb_push(1'b1, 32'hDEADBEEF);
    // IDLE cycle, then WAIT cycles 1..8; the forced grant lands on WAIT cycle 8.
    loader_xfer(1'b0, 32'h40, 32'h0, 30, lat, stalls);
    checks++; if (lat != 9) begin errors++;
      $display("FAIL t3_latency: got %0d expected 9", lat); end
    checks++; if (stalls != 1) begin errors++;
      $display("FAIL t3_stall_cycles: got %0d expected 1", stalls); end
    checks++; if (o_stall_count !== 16'd1 || o_stall_M !== 1'b0) begin errors++;
      $display("FAIL t3_stall_count: got %0d stall %b expected 1 0", o_stall_count, o_stall_M);
    end
    sb_pop(e, ok);
    checks++; if (!ok || l_if.l_rd_data !== e.data) begin errors++;
      $display("FAIL t3_rd_data: got %h expected %h", l_if.l_rd_data, e.data); end
    idle_inputs();
  endtask

  task automatic test_priority();
    sb_t e; bit ok;
    step();
    i_access_M = 1'b1; i_wr_en_M = 1'b1; i_addr_M = 32'h80; i_wr_data_M = 32'h11;
    l_if.l_req = 1'b1; l_if.l_wr_en = 1'b1; l_if.l_addr = 32'h80; l_if.l_wr_data = 32'h22;
    sb_push(1'b0, 32'h22);
    #1;
    checks++; if (o_mem_we !== 1'b1 || o_mem_wd !== 32'h11 || o_stall_M !== 1'b0) begin
      errors++;
      $display("FAIL t4_m_first: we %b wd %h stall %b expected 1 11 0",
               o_mem_we, o_mem_wd, o_stall_M);
    end
    step();
    i_access_M = 1'b0; i_wr_en_M = 1'b0; i_addr_M = 32'h40;
    #1;
    checks++; if (o_mem_we !== 1'b1 || o_mem_wd !== 32'h22 || o_mem_addr !== 32'h80) begin
      errors++;
      $display("FAIL t4_loader_next: we %b addr %h wd %h expected 1 80 22",
               o_mem_we, o_mem_addr, o_mem_wd);
    end
    step();
    #1;
    checks++; if (l_if.l_ack !== 1'b1) begin errors++;
      $display("FAIL t4_ack: got %b expected 1", l_if.l_ack); end
    l_if.l_req = 1'b0;
    sb_pop(e, ok);
    checks++; if (o_rd_data_M !== 32'hDEADBEEF) begin errors++;
      $display("FAIL t4_m_rd_data: got %h expected deadbeef", o_rd_data_M); end
    step();
    checks++; if (!ok || mem[8'h20] !== e.data) begin errors++;
      $display("FAIL t4_final_mem: got %h expected %h", mem[8'h20], e.data); end
  endtask

  task automatic test_back_to_back();
    sb_t e; bit ok; int wc0;
    logic [3:0] exp_we, exp_ack;
    exp_we  = 4'b0101;   // bit i = cycle i
    exp_ack = 4'b1010;
    step();
    wc0 = wr_count;
    l_if.l_req = 1'b1; l_if.l_wr_en = 1'b1; l_if.l_addr = 32'hC0; l_if.l_wr_data = 32'h55;
    sb_push(1'b0, 32'h55);
    sb_push(1'b0, 32'h55);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (o_mem_we !== exp_we[c] || l_if.l_ack !== exp_ack[c]) begin errors++;
        $display("FAIL t5_cycle%0d: we %b ack %b expected %b %b",
                 c, o_mem_we, l_if.l_ack, exp_we[c], exp_ack[c]);
      end
      if (l_if.l_ack) begin
        sb_pop(e, ok);
        checks++; if (!ok) begin errors++;
          $display("FAIL t5_scoreboard: ack with no expected entry (got 1 expected 0)"); end
      end
      if (c == 3) l_if.l_req = 1'b0;
      step();
    end
    #1;
    checks++; if (wr_count - wc0 != 2 || l_if.l_ack !== 1'b0) begin errors++;
      $display("FAIL t5_access_count: got %0d ack %b expected 2 0",
               wr_count - wc0, l_if.l_ack);
    end
  endtask

  task automatic test_reset_in_wait();
    int wc0, lat, stalls; sb_t e; bit ok;
    step();
    wc0 = wr_count;
    i_access_M = 1'b1; i_wr_en_M = 1'b0; i_addr_M = 32'h100;
    l_if.l_req = 1'b1; l_if.l_wr_en = 1'b1; l_if.l_addr = 32'hE0; l_if.l_wr_data = 32'h77;
    repeat (5) step();
    #1;
    checks++; if (o_mem_we !== 1'b0 || o_stall_M !== 1'b0 || o_stall_count !== 16'd1) begin
      errors++;
      $display("FAIL t6_pre_reset: we %b stall %b count %0d expected 0 0 1",
               o_mem_we, o_stall_M, o_stall_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (l_if.l_ack !== 1'b0 || l_if.l_rd_data !== 32'h0) begin errors++;
      $display("FAIL t6_after_reset: ack %b data %h expected 0 0", l_if.l_ack, l_if.l_rd_data);
    end
    checks++; if (o_stall_count !== 16'd0) begin errors++;
      $display("FAIL t6_stall_count: got %0d expected 0", o_stall_count); end
    checks++; if (wr_count != wc0 || mem[8'h38] !== 32'h0) begin errors++;
      $display("FAIL t6_no_write: writes %0d mem %h expected 0 0", wr_count - wc0, mem[8'h38]);
    end
    // Back in IDLE: an idle-M read must be granted immediately.
    step();
    sb_push(1'b1, 32'h22);
    loader_xfer(1'b0, 32'h80, 32'h0, 20, lat, stalls);
    sb_pop(e, ok);
    checks++; if (lat != 1 || !ok || l_if.l_rd_data !== e.data) begin errors++;
      $display("FAIL t6_post_read: lat %0d data %h expected 1 %h", lat, l_if.l_rd_data, e.data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (got timeout expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_share();
    test_read_back();
    test_starvation();
    test_priority();
    test_back_to_back();
    test_reset_in_wait();
    checks++; if (sb_q.size() != 0) begin errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
